// File: rtl/piso_pkg.sv
// piso_pkg: shared types and constants for the parallel-in/serial-out
// serializer.
//   piso_state_e - serializer control state (IDLE, SHIFT)
//   ORDER_LSB    - order value meaning "least significant bit first"
//   ORDER_MSB    - order value meaning "most significant bit first"
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  localparam logic ORDER_LSB = 1'b0;
  localparam logic ORDER_MSB = 1'b1;

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: frame bit counter with synchronous clear, count enable
// and a terminal-count compare.
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset (count returns to 0)
//   clear    - synchronous clear to 0, wins over enable
//   enable   - increment by one at this edge
//   cnt      - current count
//   last_bit - high while cnt equals LAST (the index of the final frame bit)
module piso_bit_counter #(
  parameter int              CNT_W = 3,
  parameter logic [CNT_W-1:0] LAST = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             last_bit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last_bit = (cnt == LAST);

endmodule : piso_bit_counter

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out serializer with a valid/ready load
// port, shift-enable stalling and a per-frame bit order.
//
// Optional feature macro: PISO_PARITY_EN. When defined, an even-parity bit
// (^load_data) is appended after the data bits, making a frame WIDTH+1 bits.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset; aborts any frame in flight
//   load_valid - upstream presents a word on load_data
//   load_ready - block can accept a word this cycle (combinational)
//   load_data  - WIDTH-bit parallel word
//   msb_first  - bit order for the word being loaded (1 = MSB first)
//   shift_en   - advance to the next bit at this edge; low stalls the frame
//   ser_out    - current serial bit (0 when idle)
//   ser_valid  - ser_out holds a frame bit
//   busy       - frame in progress
//   done       - one-cycle pulse after the edge that consumed the last bit
//   fsm_state  - current control state, for observation
//
// Handshake: a word transfers at a rising edge where load_valid and
// load_ready are both high. load_ready is also high during the final enabled
// bit of a frame, so a new word can follow with no idle cycle. load_valid
// with load_ready low is simply ignored; upstream must hold its word until
// the transfer edge.
module piso_serializer
  import piso_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             msb_first,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output piso_state_e      fsm_state
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  piso_state_e          state, next_state;
  logic [FRAME_LEN-1:0] shreg;
  logic [FRAME_LEN-1:0] load_img;
  logic                 order;
  logic [CNT_W-1:0]     cnt;
  logic                 last_bit;
  logic                 shifting;
  logic                 accept;
  logic                 frame_end;

  // The parity bit rides in the shift register beyond the data bits on the
  // side opposite the output end, so it simply falls out after the last
  // data bit for either bit order.
`ifdef PISO_PARITY_EN
  logic parity;
  assign parity   = ^load_data;
  assign load_img = (msb_first == ORDER_MSB) ? {load_data, parity}
                                             : {parity, load_data};
`else
  assign load_img = load_data;
`endif

  piso_bit_counter #(
    .CNT_W (CNT_W),
    .LAST  (LAST_CNT)
  ) u_bit_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept || frame_end),
    .enable   (shifting),
    .cnt      (cnt),
    .last_bit (last_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, handshake and status outputs.
  always_comb begin
    shifting   = 1'b0;
    frame_end  = 1'b0;
    load_ready = 1'b0;
    accept     = 1'b0;
    ser_valid  = 1'b0;
    busy       = 1'b0;
    next_state = state;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        accept     = load_valid;
        if (accept) next_state = SHIFT;
      end
      SHIFT: begin
        ser_valid  = 1'b1;
        busy       = 1'b1;
        shifting   = shift_en;
        frame_end  = shift_en && last_bit;
        load_ready = frame_end;
        accept     = load_valid && frame_end;
        if (frame_end) next_state = accept ? SHIFT : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Shift register, latched order and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      order <= ORDER_LSB;
      done  <= 1'b0;
    end else begin
      done <= frame_end;
      if (accept) begin
        shreg <= load_img;
        order <= msb_first;
      end else if (shifting) begin
        if (order == ORDER_MSB) shreg <= {shreg[FRAME_LEN-2:0], 1'b0};
        else                    shreg <= {1'b0, shreg[FRAME_LEN-1:1]};
      end
    end
  end

  assign ser_out   = (state == SHIFT) &&
                     ((order == ORDER_MSB) ? shreg[FRAME_LEN-1] : shreg[0]);
  assign fsm_state = state;

endmodule : piso_serializer
